// File: rtl/pong_pkg.sv
// Shared Pong definitions: game-flow states and screen/paddle geometry.
package pong_pkg;

  localparam int SCREEN_H       = 480;
  localparam int PADDLE_H       = 50;
  localparam int PADDLE_Y_MAX   = SCREEN_H - PADDLE_H;
  localparam int PADDLE_Y_RESET = PADDLE_Y_MAX / 2;

  typedef enum logic [1:0] {
    S_READY  = 2'd0,
    S_PLAY   = 2'd1,
    S_PAUSED = 2'd2
  } state_t;

endpackage

// File: rtl/button_debounce.sv
// Synchronises a raw push-button, debounces it and emits a one-cycle pulse
// on each accepted released->pressed transition.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int BTN_ACTIVE_LOW  = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_button,
  output logic o_pressed
);

  localparam int   CNT_W      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic ACTIVE_LOW = (BTN_ACTIVE_LOW != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_stable;
  logic             r_pressed;
  logic [CNT_W-1:0] r_count;
  logic             w_level;
  logic             w_accept;

  assign w_level   = r_sync2 ^ ACTIVE_LOW;
  assign w_accept  = (w_level != r_stable) && (r_count == CNT_LAST);
  assign o_pressed = r_pressed;

  // Synchroniser idles at the released level so reset never looks like a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= ACTIVE_LOW;
      r_sync2 <= ACTIVE_LOW;
    end else begin
      r_sync1 <= i_button;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count   <= '0;
      r_stable  <= 1'b0;
      r_pressed <= 1'b0;
    end else begin
      r_pressed <= w_accept & w_level;
      if (w_level == r_stable) begin
        r_count <= '0;
      end else if (w_accept) begin
        r_stable <= w_level;
        r_count  <= '0;
      end else begin
        r_count <= r_count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/paddle_controller.sv
// Paddle position register and ready/play/paused game-flow FSM driven by
// encoder pulses, a debounced encoder button and the point-scored event.
module paddle_controller
  import pong_pkg::*;
#(
  parameter int Y_WIDTH         = 10,
  parameter int Y_MIN           = 0,
  parameter int Y_MAX           = PADDLE_Y_MAX,
  parameter int Y_RESET         = PADDLE_Y_RESET,
  parameter int STEP            = 8,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int BTN_ACTIVE_LOW  = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               up,
  input  logic               down,
  input  logic               button,
  input  logic               point_scored,
  output logic [Y_WIDTH-1:0] paddle_y,
  output logic               serve,
  output logic               paused,
  output logic               btn_pressed
);

  localparam int EW = Y_WIDTH + 1;
  localparam logic [EW-1:0] C_MIN   = EW'(Y_MIN);
  localparam logic [EW-1:0] C_MAX   = EW'(Y_MAX);
  localparam logic [EW-1:0] C_STEP  = EW'(STEP);
  localparam logic [EW-1:0] C_RESET = EW'(Y_RESET);

  logic [EW-1:0] r_y;
  logic [EW-1:0] w_y_up;
  logic [EW-1:0] w_y_down;
  state_t        r_state;
  state_t        w_state_next;
  logic          r_serve;
  logic          w_serve_next;
  logic          w_press;

  button_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .BTN_ACTIVE_LOW  (BTN_ACTIVE_LOW)
  ) u_debounce (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_button  (button),
    .o_pressed (w_press)
  );

  // The extra headroom bit keeps the down-step sum from wrapping before the clamp.
  assign w_y_up   = (r_y < C_MIN + C_STEP) ? C_MIN : r_y - C_STEP;
  assign w_y_down = (r_y + C_STEP > C_MAX) ? C_MAX : r_y + C_STEP;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y <= C_RESET;
    end else if (point_scored) begin
      r_y <= C_RESET;
    end else if ((r_state != S_PAUSED) && (up ^ down)) begin
      r_y <= up ? w_y_up : w_y_down;
    end
  end

  // A scored point always recentres to READY and swallows a coincident press.
  always_comb begin
    w_state_next = r_state;
    w_serve_next = 1'b0;
    if (point_scored) begin
      w_state_next = S_READY;
    end else if (w_press) begin
      case (r_state)
        S_READY: begin
          w_state_next = S_PLAY;
          w_serve_next = 1'b1;
        end
        S_PLAY:   w_state_next = S_PAUSED;
        S_PAUSED: w_state_next = S_PLAY;
        default:  w_state_next = S_READY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_READY;
      r_serve <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_serve <= w_serve_next;
    end
  end

  assign paddle_y    = r_y[Y_WIDTH-1:0];
  assign serve       = r_serve;
  assign paused      = (r_state == S_PAUSED);
  assign btn_pressed = w_press;

endmodule

// File: tb/tb_paddle_controller.sv
// Randomised, model-checked bench for paddle_controller with a short debounce.
module tb_paddle_controller;

  localparam int D     = 4;
  localparam int YMAX  = 430;
  localparam int YRST  = 215;
  localparam int STEPV = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       up;
  logic       down;
  logic       button;
  logic       point_scored;
  logic [9:0] paddle_y;
  logic       serve;
  logic       paused;
  logic       btn_pressed;

  int errors = 0;
  int checks = 0;
  int cycleDiffs = 0;

  // Behavioural model: mode 0=ready, 1=play, 2=paused
  int mY;
  int mMode;
  bit mServe;
  bit mBtn;
  bit hist0;
  bit hist1;
  bit mStable;
  int mRun;

  always #5 clk = ~clk;

  paddle_controller #(.DEBOUNCE_CYCLES(D)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .up           (up),
    .down         (down),
    .button       (button),
    .point_scored (point_scored),
    .paddle_y     (paddle_y),
    .serve        (serve),
    .paused       (paused),
    .btn_pressed  (btn_pressed)
  );

  task automatic modelReset();
    mY = YRST; mMode = 0; mServe = 0; mBtn = 0;
    hist0 = 1; hist1 = 1; mStable = 0; mRun = 0;
  endtask

  // Drive one cycle of inputs, advance the model, and tally any disagreement.
  task automatic step(input bit u, input bit d, input bit b, input bit p);
    bit synced;
    bit prevBtn;
    int oldMode;
    up = u; down = d; button = b; point_scored = p;
    @(posedge clk);
    synced = ~hist1;
    hist1 = hist0;
    hist0 = b;
    prevBtn = mBtn;
    mBtn = 0;
    if (synced != mStable) begin
      mRun++;
      if (mRun == D) begin
        mStable = synced;
        mBtn = synced;
        mRun = 0;
      end
    end else begin
      mRun = 0;
    end
    oldMode = mMode;
    mServe = 0;
    if (p) begin
      mMode = 0;
      mY = YRST;
    end else begin
      if (oldMode != 2 && u != d)
        mY = u ? ((mY - STEPV < 0) ? 0 : mY - STEPV)
               : ((mY + STEPV > YMAX) ? YMAX : mY + STEPV);
      if (prevBtn) begin
        if (oldMode == 0) begin mMode = 1; mServe = 1; end
        else if (oldMode == 1) mMode = 2;
        else mMode = 1;
      end
    end
    @(negedge clk);
    if ({paddle_y, serve, paused, btn_pressed} !== {10'(mY), mServe, (mMode == 2), mBtn})
      cycleDiffs++;
  endtask

  task automatic pressAndRelease(output int events, output int serves);
    events = 0; serves = 0;
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0, 0);
      events += int'(btn_pressed); serves += int'(serve);
    end
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 1, 0);
      events += int'(btn_pressed); serves += int'(serve);
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({paddle_y, serve, paused, btn_pressed} !== {10'd215, 3'b000}) begin
      errors++;
      $display("[TB] FAIL reset_state: got y=%0d s=%0b p=%0b b=%0b expected y=215 s=0 p=0 b=0",
               paddle_y, serve, paused, btn_pressed);
    end
  endtask

  task automatic test_movement();
    int d0 = cycleDiffs;
    for (int i = 1; i <= 3; i++) begin
      step(0, 1, 1, 0);
      checks++;
      if (paddle_y !== 10'(YRST + STEPV * i)) begin
        errors++;
        $display("[TB] FAIL move_down%0d: got %0d expected %0d", i, paddle_y, YRST + STEPV * i);
      end
    end
    step(1, 1, 1, 0);
    checks++;
    if (paddle_y !== 10'd239) begin
      errors++;
      $display("[TB] FAIL up_and_down: got %0d expected 239", paddle_y);
    end
    checks++;
    if (cycleDiffs != d0) begin
      errors++;
      $display("[TB] FAIL movement_model: got %0d diffs expected 0", cycleDiffs - d0);
    end
  endtask

  task automatic test_saturation();
    int d0 = cycleDiffs;
    for (int i = 0; i < 23; i++) step(0, 1, 1, 0);
    checks++;
    if (paddle_y !== 10'd423) begin
      errors++;
      $display("[TB] FAIL approach_max: got %0d expected 423", paddle_y);
    end
    step(0, 1, 1, 0);
    checks++;
    if (paddle_y !== 10'd430) begin
      errors++;
      $display("[TB] FAIL clamp_max: got %0d expected 430", paddle_y);
    end
    step(0, 1, 1, 0);
    checks++;
    if (paddle_y !== 10'd430) begin
      errors++;
      $display("[TB] FAIL hold_max: got %0d expected 430", paddle_y);
    end
    for (int i = 0; i < 53; i++) step(1, 0, 1, 0);
    checks++;
    if (paddle_y !== 10'd6) begin
      errors++;
      $display("[TB] FAIL approach_min: got %0d expected 6", paddle_y);
    end
    step(1, 0, 1, 0);
    checks++;
    if (paddle_y !== 10'd0) begin
      errors++;
      $display("[TB] FAIL clamp_min: got %0d expected 0", paddle_y);
    end
    step(1, 0, 1, 0);
    checks++;
    if (paddle_y !== 10'd0 || cycleDiffs != d0) begin
      errors++;
      $display("[TB] FAIL hold_min: got y=%0d diffs=%0d expected y=0 diffs=0", paddle_y, cycleDiffs - d0);
    end
  endtask

  task automatic test_debounce();
    int d0 = cycleDiffs;
    int events = 0;
    int serves = 0;
    int latency = -1;
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    for (int i = 1; i <= 11; i++) begin
      step(0, 0, 0, 0);
      if (btn_pressed) begin
        events++;
        if (latency < 0) latency = i;
      end
      serves += int'(serve);
    end
    checks++;
    if (events != 1) begin
      errors++;
      $display("[TB] FAIL press_event_count: got %0d expected 1", events);
    end
    checks++;
    if (latency != 2 + D) begin
      errors++;
      $display("[TB] FAIL press_latency: got %0d expected %0d", latency, 2 + D);
    end
    checks++;
    if (serves != 1 || paused !== 1'b0) begin
      errors++;
      $display("[TB] FAIL serve_from_ready: got serves=%0d paused=%0b expected 1 and 0", serves, paused);
    end
    events = 0;
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    for (int i = 0; i < 12; i++) begin
      step(0, 0, 1, 0);
      events += int'(btn_pressed);
    end
    checks++;
    if (events != 0 || cycleDiffs != d0) begin
      errors++;
      $display("[TB] FAIL release_bounce: got events=%0d diffs=%0d expected 0 and 0", events, cycleDiffs - d0);
    end
  endtask

  task automatic test_fsm();
    int d0 = cycleDiffs;
    int events;
    int serves;
    logic [9:0] yBefore;
    pressAndRelease(events, serves);
    checks++;
    if (paused !== 1'b1 || serves != 0 || events != 1) begin
      errors++;
      $display("[TB] FAIL play_to_paused: got paused=%0b serves=%0d events=%0d expected 1 0 1",
               paused, serves, events);
    end
    yBefore = paddle_y;
    step(0, 1, 1, 0);
    checks++;
    if (paddle_y !== yBefore) begin
      errors++;
      $display("[TB] FAIL move_while_paused: got %0d expected %0d", paddle_y, yBefore);
    end
    pressAndRelease(events, serves);
    checks++;
    if (paused !== 1'b0 || serves != 0) begin
      errors++;
      $display("[TB] FAIL unpause: got paused=%0b serves=%0d expected 0 and 0", paused, serves);
    end
    checks++;
    if (cycleDiffs != d0) begin
      errors++;
      $display("[TB] FAIL fsm_model: got %0d diffs expected 0", cycleDiffs - d0);
    end
  endtask

  task automatic test_point();
    int d0 = cycleDiffs;
    int guard = 0;
    for (int i = 0; i < 37; i++) step(0, 1, 1, 0);
    checks++;
    if (paddle_y !== 10'd296) begin
      errors++;
      $display("[TB] FAIL point_setup: got %0d expected 296", paddle_y);
    end
    step(0, 0, 0, 0);
    while (btn_pressed !== 1'b1 && guard < 20) begin
      step(0, 0, 0, 0);
      guard++;
    end
    checks++;
    if (btn_pressed !== 1'b1) begin
      errors++;
      $display("[TB] FAIL point_press_wait: got btn_pressed=%0b expected 1", btn_pressed);
    end
    step(0, 1, 0, 1);
    checks++;
    if ({paddle_y, serve, paused} !== {10'd215, 2'b00}) begin
      errors++;
      $display("[TB] FAIL point_recentre: got y=%0d s=%0b p=%0b expected y=215 s=0 p=0",
               paddle_y, serve, paused);
    end
    step(0, 0, 0, 0);
    checks++;
    if (serve !== 1'b0 || paused !== 1'b0) begin
      errors++;
      $display("[TB] FAIL point_drops_press: got s=%0b p=%0b expected 0 0", serve, paused);
    end
    for (int i = 0; i < 10; i++) step(0, 0, 1, 0);
    checks++;
    if (cycleDiffs != d0) begin
      errors++;
      $display("[TB] FAIL point_model: got %0d diffs expected 0", cycleDiffs - d0);
    end
  endtask

  task automatic test_async_reset();
    int events;
    int serves;
    pressAndRelease(events, serves);
    pressAndRelease(events, serves);
    step(0, 1, 1, 0);
    checks++;
    if (paused !== 1'b1) begin
      errors++;
      $display("[TB] FAIL pre_reset_paused: got %0b expected 1", paused);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({paddle_y, serve, paused, btn_pressed} !== {10'd215, 3'b000}) begin
      errors++;
      $display("[TB] FAIL async_reset: got y=%0d s=%0b p=%0b b=%0b expected y=215 s=0 p=0 b=0",
               paddle_y, serve, paused, btn_pressed);
    end
    @(negedge clk);
    rst_n = 1'b1;
    modelReset();
  endtask

  task automatic test_random();
    int d0 = cycleDiffs;
    int hold = 0;
    int doubleServe = 0;
    bit b = 1;
    bit prevServe = 0;
    for (int i = 0; i < 1500; i++) begin
      if (hold == 0) begin
        b = ~b;
        hold = $urandom_range(1, 8);
      end
      hold--;
      step(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) == 0), b,
           1'($urandom_range(0, 39) == 0));
      if (serve && prevServe) doubleServe++;
      prevServe = serve;
    end
    checks++;
    if (cycleDiffs != d0) begin
      errors++;
      $display("[TB] FAIL random_model: got %0d diffs expected 0", cycleDiffs - d0);
    end
    checks++;
    if (doubleServe != 0) begin
      errors++;
      $display("[TB] FAIL serve_single_cycle: got %0d doubles expected 0", doubleServe);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0; up = 0; down = 0; button = 1; point_scored = 0;
    modelReset();
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    test_movement();
    test_saturation();
    test_debounce();
    test_fsm();
    test_point();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
